// File: rtl/led_duty_sequencer.sv
// -----------------------------------------------------------------------------
// led_duty_sequencer
//   Breathing-pattern source for the LED PWM block. One channel at a time, the
//   duty value ramps up to full scale, ramps back down to zero, and then the
//   sequencer moves on to the next channel. Every new (duty, channel) pair is
//   offered downstream over a valid/ready handshake. Ramp speed comes from an
//   internal prescaler.
//
// Optional feature:
//   LED_GAMMA_EN : when defined, duty_out = (lin*lin) >> DUTY_W (a simple
//                  perceptual gamma curve); when undefined, duty_out = lin.
//
// Ports:
//   saatDarbesi : system clock, all logic on the rising edge
//   sifirla_n   : synchronous active-low reset
//   enable      : run; low freezes sequencing (a pending handshake still ends)
//   duty_ready  : downstream accepts the current duty
//   duty_valid  : duty_out/ch_sel hold a pending update
//   duty_out    : duty value for channel ch_sel
//   ch_sel      : channel that duty_out applies to
//   pass_done   : one-cycle pulse when ch_sel wraps N_CH-1 -> 0
// -----------------------------------------------------------------------------
module led_duty_sequencer #(
  parameter int PRESCALE_MAX = 1000000,
  parameter int DUTY_W       = 7,
  parameter int STEP         = 1,
  parameter int N_CH         = 8,
  parameter int CH_W         = 3
) (
  input  logic              saatDarbesi,
  input  logic              sifirla_n,
  input  logic              enable,
  input  logic              duty_ready,
  output logic              duty_valid,
  output logic [DUTY_W-1:0] duty_out,
  output logic [CH_W-1:0]   ch_sel,
  output logic              pass_done
);

  localparam int                PS_W    = (PRESCALE_MAX > 1) ? $clog2(PRESCALE_MAX) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE_MAX - 1);
  localparam logic [DUTY_W:0]   STEP_X  = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W-1:0] STEP_D  = DUTY_W'(STEP);
  localparam logic [DUTY_W:0]   DMAX_X  = {1'b0, {DUTY_W{1'b1}}};
  localparam logic [DUTY_W-1:0] DMAX_D  = {DUTY_W{1'b1}};
  localparam logic [CH_W-1:0]   CH_LAST = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DOWN = 2'd1,
    ST_ADV  = 2'd2
  } state_t;

  state_t            state_r;
  logic [PS_W-1:0]   ps_r;
  logic [DUTY_W-1:0] lin_r;
  logic [CH_W-1:0]   ch_r;
  logic              valid_r;
  logic              pass_done_r;

  logic              stall_s;
  logic              count_s;
  logic              tick_s;
  logic              xfer_s;
  logic [DUTY_W:0]   up_sum_s;
  logic [DUTY_W-1:0] dn_diff_s;

`ifdef LED_GAMMA_EN
  // Square-law brightness curve: (lin*lin) >> DUTY_W, full product width.
  function automatic logic [DUTY_W-1:0] gamma_map(input logic [DUTY_W-1:0] lin);
    logic [2*DUTY_W-1:0] sq;
    sq = {{DUTY_W{1'b0}}, lin} * {{DUTY_W{1'b0}}, lin};
    return DUTY_W'(sq >> DUTY_W);
  endfunction
`endif

  // Handshake/prescaler qualifiers and the one-step ramp arithmetic.
  always_comb begin
    stall_s   = valid_r & ~duty_ready;
    count_s   = enable & ~stall_s;
    tick_s    = count_s & (ps_r == PS_LAST);
    xfer_s    = valid_r & duty_ready;
    // One extra bit so the upward step can be saturated instead of wrapping.
    up_sum_s  = {1'b0, lin_r} + STEP_X;
    // Only consumed when lin_r > STEP, so it never underflows.
    dn_diff_s = lin_r - STEP_D;
  end

  // Sequencer: prescaler, ramp FSM, channel index and handshake registers.
  always_ff @(posedge saatDarbesi) begin
    if (!sifirla_n) begin
      state_r     <= ST_UP;
      ps_r        <= '0;
      lin_r       <= '0;
      ch_r        <= '0;
      valid_r     <= 1'b0;
      pass_done_r <= 1'b0;
    end else begin
      if (count_s) begin
        ps_r <= tick_s ? '0 : (ps_r + PS_W'(1'b1));
      end else begin
        ps_r <= ps_r;
      end

      pass_done_r <= 1'b0;

      // A tick always produces a fresh update; it can only fire when the
      // previous value is not stalled, so the held value is never overwritten.
      if (tick_s) begin
        valid_r <= 1'b1;
        case (state_r)
          ST_UP: begin
            if (up_sum_s >= DMAX_X) begin
              lin_r   <= DMAX_D;
              state_r <= ST_DOWN;
            end else begin
              lin_r   <= up_sum_s[DUTY_W-1:0];
            end
          end
          ST_DOWN: begin
            if (lin_r <= STEP_D) begin
              lin_r   <= '0;
              state_r <= ST_ADV;
            end else begin
              lin_r   <= dn_diff_s;
            end
          end
          ST_ADV: begin
            lin_r   <= STEP_D;
            state_r <= ST_UP;
            if (ch_r == CH_LAST) begin
              ch_r        <= '0;
              pass_done_r <= 1'b1;
            end else begin
              ch_r        <= ch_r + CH_W'(1'b1);
            end
          end
          default: begin
            lin_r   <= '0;
            state_r <= ST_UP;
          end
        endcase
      end else if (xfer_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign duty_valid = valid_r;
  assign ch_sel     = ch_r;
  assign pass_done  = pass_done_r;
`ifdef LED_GAMMA_EN
  assign duty_out   = gamma_map(lin_r);
`else
  assign duty_out   = lin_r;
`endif

endmodule
